dds_cmd_sequencer: RTL and testbench
====================================

DDS_CMD_SEQUENCER -- requirements
Module: dds_cmd_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 2, clk cycles per SCLK half-period (legal range 1..255).
REQ-002 Parameter TIMEOUT, default 50000, max clk cycles allowed between payload bytes.
REQ-003 Parameter UPD_W, default 4, IO_UPDATE pulse width in clk cycles.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 rx_valid  in  1  one-cycle strobe, byte received from UART.
REQ-007 rx_data  in  8  received byte, valid while rx_valid=1.
REQ-008 tx_busy  in  1  UART transmitter busy; tx_start is not issued while 1.
REQ-009 tx_start  out  1  one-cycle strobe requesting transmission of tx_data.
REQ-010 tx_data  out  8  byte to transmit, held stable from tx_start until tx_busy falls.
REQ-011 CS  out  1  DDS serial chip select, active low.
REQ-012 SCLK  out  1  DDS serial clock, idle low.
REQ-013 SDIO  out  1  DDS serial data in, MSB first.
REQ-014 SDO  in  1  DDS serial data out (readback).
REQ-015 IO_UPDATE  out  1  DDS register transfer pulse, active high.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 err  out  1  one-cycle pulse on any frame error.

Function
REQ-018 Frame: header byte H (H[7]=1 read, 0 write; H[4:0]=register address) followed by N payload bytes on write, none on read.
REQ-019 N = 4 for address 0x00..0x0D, N = 8 for 0x0E..0x15; any other address, or H[6:5]!=0, is an invalid header.
REQ-020 States: IDLE, RX_PAY, SHIFT, CS_GAP, UPDATE, REPLY.
REQ-021 IDLE: valid write header -> RX_PAY; valid read header -> SHIFT; invalid header -> REPLY with code 0xEE and err pulse.
REQ-022 RX_PAY: store bytes MSB-first into a 64-bit buffer; after the Nth byte -> SHIFT next cycle.
REQ-023 RX_PAY: inter-byte counter reset on each rx_valid; reaching TIMEOUT -> discard frame, err pulse, REPLY code 0xEE.
REQ-024 rx_valid in SHIFT, CS_GAP, UPDATE or REPLY: byte dropped, err pulse, no state change.
REQ-025 SHIFT entry: CS low one CLK_DIV period before first SCLK rising edge; SDIO updated only while SCLK low.
REQ-026 SCLK: low CLK_DIV cycles, high CLK_DIV cycles per bit; DDS samples SDIO on rising edge.
REQ-027 Write shift: 8 header bits then 8*N payload bits (40 or 72 SCLK periods); read shift: 8 header bits then 8*N bits sampled from SDO at the clk cycle of each SCLK rising edge.
REQ-028 After last SCLK falling edge: CS high, SCLK low, SDIO low, -> CS_GAP for 2*CLK_DIV cycles.
REQ-029 CS_GAP exit: write -> UPDATE; read -> REPLY.
REQ-030 UPDATE: IO_UPDATE high exactly UPD_W cycles, then -> REPLY with code 0xA5.
REQ-031 REPLY: write/error sends 1 byte; read sends N captured bytes MSB-byte first; each tx_start issued only when tx_busy=0 and at least one cycle after previous tx_busy fall.
REQ-032 REPLY done (last byte accepted, tx_busy back to 0) -> IDLE.
REQ-033 Total write latency: last payload rx_valid to IO_UPDATE rise = 1 + CLK_DIV + 2*CLK_DIV*(8+8N) + 2*CLK_DIV cycles (exact, bench-checked).

Reset
REQ-034 rst asserted: state IDLE, CS=1, SCLK=0, SDIO=0, IO_UPDATE=0, tx_start=0, tx_data=0x00, busy=0, err=0, buffers and counters cleared, asynchronously.
REQ-035 rst mid-SHIFT: CS rises immediately, no IO_UPDATE and no reply issued for aborted frame.

Verification
REQ-036 Write: bytes 0x01,0x11,0x22,0x33,0x44 (CLK_DIV=2) -> 40 SCLK periods, SDIO stream 0x0111223344, IO_UPDATE 4-cycle pulse at REQ-033 latency, reply 0xA5.
REQ-037 Read: byte 0x8E, SDO model returns 0x0123456789ABCDEF -> 72 SCLK periods, no IO_UPDATE, replies 0x01,0x23,...,0xEF in order.
REQ-038 Invalid: byte 0x1F -> err pulse, CS stays 1, reply 0xEE, busy low afterward.
REQ-039 Timeout: 0x02 then 2 bytes, then silence TIMEOUT cycles -> err pulse, reply 0xEE, no CS activity; next frame processes normally.
REQ-040 Reset mid-shift: assert rst at bit 20 of a write -> all outputs at REQ-034 values same cycle; post-reset write completes correctly.
REQ-041 Busy drop: extra byte during SHIFT -> err pulse, shifted stream unchanged; tx_busy held high 1000 cycles in REPLY -> tx_start deferred until release.

Source files
------------

// File: rtl/dds_cmd_sequencer.sv
// UART-command to DDS serial-port sequencer: receives a header plus payload, shifts the
// frame out on CS/SCLK/SDIO (capturing SDO on reads), pulses IO_UPDATE, then replies.
module dds_cmd_sequencer #(
    parameter int CLK_DIV = 2,
    parameter int TIMEOUT = 50000,
    parameter int UPD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       CS,
    output logic       SCLK,
    output logic       SDIO,
    input  logic       SDO,
    output logic       IO_UPDATE,
    output logic       busy,
    output logic       err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [15:0]   DIV_M1 = 16'(CLK_DIV - 1);
    localparam logic [15:0]   GAP_M1 = 16'(2 * CLK_DIV - 1);
    localparam logic [15:0]   UPD_M1 = 16'(UPD_W - 1);
    localparam logic [TW-1:0] TMO_M1 = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RX_PAY, SHIFT, CS_GAP, UPDATE, REPLY} state_t;

    state_t        state;
    logic [7:0]    hdr;
    logic          rd;
    logic          n8;
    logic [63:0]   pay_buf;
    logic [2:0]    pay_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [15:0]   cnt;
    logic [7:0]    hp;
    logic [6:0]    bitn;
    logic [71:0]   sh;
    logic [63:0]   cap;
    logic [63:0]   rbuf;
    logic [3:0]    rcnt;
    logic          pending;
    logic          tx_busy_q;

    logic        hdr_ok;
    logic        hdr_n8;
    logic [63:0] pay_nxt;
    logic [7:0]  last_hp;

    assign hdr_ok  = (rx_data[6:5] == 2'b00) && (rx_data[4:0] <= 5'h15);
    assign hdr_n8  = (rx_data[4:0] >= 5'h0E);
    assign pay_nxt = {pay_buf[55:0], rx_data};
    // half-period index: 0 is the CS setup phase, then low/high pairs per bit
    assign last_hp = n8 ? 8'd144 : 8'd80;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hdr       <= 8'h00;
            rd        <= 1'b0;
            n8        <= 1'b0;
            pay_buf   <= '0;
            pay_cnt   <= '0;
            tmo_cnt   <= '0;
            cnt       <= '0;
            hp        <= '0;
            bitn      <= '0;
            sh        <= '0;
            cap       <= '0;
            rbuf      <= '0;
            rcnt      <= '0;
            pending   <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            CS        <= 1'b1;
            SCLK      <= 1'b0;
            SDIO      <= 1'b0;
            IO_UPDATE <= 1'b0;
            err       <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            err       <= 1'b0;
            tx_busy_q <= tx_busy;
            if (rx_valid && state != IDLE && state != RX_PAY)
                err <= 1'b1;

            case (state)
                IDLE: if (rx_valid) begin
                    hdr <= rx_data;
                    rd  <= rx_data[7];
                    n8  <= hdr_n8;
                    if (!hdr_ok) begin
                        err   <= 1'b1;
                        state <= REPLY;
                        rbuf  <= {8'hEE, 56'h0};
                        rcnt  <= 4'd1;
                    end else if (rx_data[7]) begin
                        state <= SHIFT;
                        sh    <= {rx_data, 64'h0};
                        CS    <= 1'b0;
                        SCLK  <= 1'b0;
                        SDIO  <= 1'b0;
                        cnt   <= '0;
                        hp    <= '0;
                        bitn  <= '0;
                        cap   <= '0;
                    end else begin
                        state   <= RX_PAY;
                        pay_buf <= '0;
                        pay_cnt <= '0;
                        tmo_cnt <= '0;
                    end
                end

                RX_PAY: if (rx_valid) begin
                    pay_buf <= pay_nxt;
                    tmo_cnt <= '0;
                    if (pay_cnt == (n8 ? 3'd7 : 3'd3)) begin
                        state <= SHIFT;
                        sh    <= n8 ? {hdr, pay_nxt} : {hdr, pay_nxt[31:0], 32'h0};
                        CS    <= 1'b0;
                        SCLK  <= 1'b0;
                        SDIO  <= 1'b0;
                        cnt   <= '0;
                        hp    <= '0;
                        bitn  <= '0;
                        cap   <= '0;
                    end else begin
                        pay_cnt <= pay_cnt + 3'd1;
                    end
                end else if (tmo_cnt == TMO_M1) begin
                    err   <= 1'b1;
                    state <= REPLY;
                    rbuf  <= {8'hEE, 56'h0};
                    rcnt  <= 4'd1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end

                SHIFT: if (cnt == DIV_M1) begin
                    cnt <= '0;
                    if (hp == last_hp) begin
                        CS    <= 1'b1;
                        SCLK  <= 1'b0;
                        SDIO  <= 1'b0;
                        state <= CS_GAP;
                    end else begin
                        hp <= hp + 8'd1;
                        if (!hp[0]) begin
                            SCLK <= 1'b0;
                            SDIO <= sh[71];
                            sh   <= {sh[70:0], 1'b0};
                        end else begin
                            // SDO is captured on the same clk edge that raises SCLK
                            SCLK <= 1'b1;
                            bitn <= bitn + 7'd1;
                            if (rd && bitn >= 7'd8)
                                cap <= {cap[62:0], SDO};
                        end
                    end
                end else begin
                    cnt <= cnt + 16'd1;
                end

                CS_GAP: if (cnt == GAP_M1) begin
                    cnt <= '0;
                    if (rd) begin
                        state <= REPLY;
                        rbuf  <= n8 ? cap : {cap[31:0], 32'h0};
                        rcnt  <= n8 ? 4'd8 : 4'd4;
                    end else begin
                        state     <= UPDATE;
                        IO_UPDATE <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 16'd1;
                end

                UPDATE: if (cnt == UPD_M1) begin
                    cnt       <= '0;
                    IO_UPDATE <= 1'b0;
                    state     <= REPLY;
                    rbuf      <= {8'hA5, 56'h0};
                    rcnt      <= 4'd1;
                end else begin
                    cnt <= cnt + 16'd1;
                end

                REPLY: begin
                    // pending holds off the next byte until the UART has acknowledged with busy
                    if (tx_busy)
                        pending <= 1'b0;
                    if (rcnt != 4'd0 && !tx_start && !pending && !tx_busy && !tx_busy_q) begin
                        tx_start <= 1'b1;
                        tx_data  <= rbuf[63:56];
                        rbuf     <= {rbuf[55:0], 8'h00};
                        rcnt     <= rcnt - 4'd1;
                        pending  <= 1'b1;
                    end else if (rcnt == 4'd0 && !tx_start && !pending && !tx_busy) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_cmd_sequencer.sv
// Directed bench for dds_cmd_sequencer: UART and DDS SDO models, frame monitors,
// and hand-computed expectations for write, read, error, timeout, reset and busy cases.
module tb_dds_cmd_sequencer;

    localparam int CLK_DIV = 2;
    localparam int TIMEOUT = 200;
    localparam int UPD_W   = 4;
    localparam int LAT4    = 1 + CLK_DIV + 2*CLK_DIV*40 + 2*CLK_DIV;  // 167
    localparam int LAT8    = 1 + CLK_DIV + 2*CLK_DIV*72 + 2*CLK_DIV;  // 295

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       hold_busy = 1'b0;
    logic       ub = 1'b0;
    int         ucnt = 0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       CS, SCLK, SDIO, IO_UPDATE, busy, err;
    logic       sdo = 1'b0;

    assign tx_busy = ub | hold_busy;

    dds_cmd_sequencer #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .UPD_W(UPD_W)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .CS(CS), .SCLK(SCLK), .SDIO(SDIO), .SDO(sdo),
        .IO_UPDATE(IO_UPDATE), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0, t_rx = 0, t_upd = 0;
    int err_cnt = 0, upd_rises = 0, upd_cycles = 0, n_rep = 0, viol = 0, cs_falls = 0;
    int nclk = 0, last_bits = 0, sdo_n = 0;
    logic [79:0] mosi = '0, last_mosi = '0;
    logic [63:0] sdo_sh = 64'h0123456789ABCDEF;
    logic [7:0]  rep [0:63];
    logic        upd_prev = 1'b0, txb_prev = 1'b0;
    int e0, u0, w0, r0, c0, tl;

    always @(posedge clk) cyc++;

    // UART: busy the cycle after tx_start, for 8 cycles
    always @(posedge clk) begin
        if (tx_start) begin
            ub   <= 1'b1;
            ucnt <= 8;
        end else if (ucnt > 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) ub <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (err) err_cnt++;
        if (IO_UPDATE) upd_cycles++;
        if (IO_UPDATE && !upd_prev) begin
            upd_rises++;
            t_upd = cyc;
        end
        upd_prev = IO_UPDATE;
        if (tx_start) begin
            if (n_rep < 64) rep[n_rep] = tx_data;
            n_rep++;
            if (tx_busy || txb_prev) viol++;
        end
        txb_prev = tx_busy;
    end

    always @(negedge CS) cs_falls++;

    always @(posedge SCLK or posedge CS) begin
        if (CS) begin
            if (nclk != 0) begin
                last_bits = nclk;
                last_mosi = mosi;
            end
            nclk = 0;
            mosi = '0;
        end else begin
            mosi = {mosi[78:0], SDIO};
            nclk++;
        end
    end

    // DDS readback model: data bits follow the 8 header bits, changed on SCLK fall
    always @(posedge CS or negedge SCLK) begin
        if (CS) begin
            sdo_n  = 0;
            sdo    = 1'b0;
            sdo_sh = 64'h0123456789ABCDEF;
        end else begin
            sdo_n++;
            if (sdo_n >= 8) begin
                sdo    = sdo_sh[63];
                sdo_sh = {sdo_sh[62:0], 1'b0};
            end
        end
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        t_rx     = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_write(input logic [7:0] h, input logic [63:0] pay, input int n);
        send(h);
        for (int i = 0; i < n; i++) send(pay[8*(n-1-i) +: 8]);
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {79'h0, busy}, 80'h0);
    endtask

    task automatic wait_bits(input int k);
        int n = 0;
        while (nclk < k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("bit position reached", nclk, k);
    endtask

    task automatic snap();
        e0 = err_cnt; u0 = upd_rises; w0 = upd_cycles; r0 = n_rep; c0 = cs_falls;
    endtask

    initial begin
        logic [63:0] got;
        repeat (3) @(negedge clk);
        chk("reset outputs", {CS, SCLK, SDIO, IO_UPDATE, tx_start, busy, err, tx_data}, {1'b1, 6'b0, 8'h00});
        @(posedge clk);
        #1 rst = 1'b0;

        // write, N=4
        snap();
        send_write(8'h01, 64'h11223344, 4);
        wait_idle(2000, "write idle");
        chk("write sclk count", last_bits, 40);
        chk("write sdio stream", last_mosi, 80'h0111223344);
        chk("write update pulses", upd_rises - u0, 1);
        chk("write update width", upd_cycles - w0, UPD_W);
        chk("write latency", t_upd - t_rx, LAT4);
        chk("write reply count", n_rep - r0, 1);
        chk("write reply", rep[r0], 8'hA5);
        chk("write err", err_cnt - e0, 0);

        // read, N=8
        snap();
        send(8'h8E);
        wait_idle(3000, "read idle");
        chk("read sclk count", last_bits, 72);
        chk("read sdio stream", last_mosi, {8'h00, 8'h8E, 64'h0});
        chk("read no update", upd_rises - u0, 0);
        chk("read reply count", n_rep - r0, 8);
        got = '0;
        for (int i = 0; i < 8; i++) got = {got[55:0], rep[r0 + i]};
        chk("read reply bytes", got, 64'h0123456789ABCDEF);

        // invalid header
        snap();
        send(8'h1F);
        wait_idle(500, "invalid idle");
        chk("invalid err pulse", err_cnt - e0, 1);
        chk("invalid cs quiet", cs_falls - c0, 0);
        chk("invalid reply count", n_rep - r0, 1);
        chk("invalid reply", rep[r0], 8'hEE);

        // timeout after two of four payload bytes
        snap();
        send(8'h02);
        send(8'hAA);
        send(8'hBB);
        repeat (TIMEOUT - 5) @(negedge clk);
        chk("timeout not early", err_cnt - e0, 0);
        wait_idle(2000, "timeout idle");
        chk("timeout err pulse", err_cnt - e0, 1);
        chk("timeout cs quiet", cs_falls - c0, 0);
        chk("timeout reply", rep[r0], 8'hEE);
        chk("timeout no update", upd_rises - u0, 0);
        snap();
        send_write(8'h03, 64'hAABBCCDD, 4);
        wait_idle(2000, "post-timeout idle");
        chk("post-timeout sdio", last_mosi, 80'h03AABBCCDD);
        chk("post-timeout reply", rep[r0], 8'hA5);
        chk("post-timeout err", err_cnt - e0, 0);

        // reset at bit 20 of a write
        snap();
        send_write(8'h05, 64'h12345678, 4);
        wait_bits(20);
        rst = 1'b1;
        #1;
        chk("rst mid-shift outputs", {CS, SCLK, SDIO, IO_UPDATE, tx_start, busy, err, tx_data}, {1'b1, 6'b0, 8'h00});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("aborted no update", upd_rises - u0, 0);
        chk("aborted no reply", n_rep - r0, 0);
        chk("aborted idle", {31'h0, busy}, 0);
        snap();
        send_write(8'h0D, 64'hDEADBEEF, 4);
        wait_idle(2000, "post-reset idle");
        chk("post-reset sdio", last_mosi, 80'h0DDEADBEEF);
        chk("post-reset latency", t_upd - t_rx, LAT4);
        chk("post-reset reply", rep[r0], 8'hA5);

        // extra byte during shift, then UART held busy through REPLY
        snap();
        send_write(8'h0E, 64'h0102030405060708, 8);
        tl = t_rx;
        wait_bits(10);
        send(8'h55);
        hold_busy = 1'b1;
        repeat (1000) @(negedge clk);
        chk("held no tx_start", n_rep - r0, 0);
        chk("held still busy", {31'h0, busy}, 1);
        hold_busy = 1'b0;
        wait_idle(500, "release idle");
        chk("drop err pulse", err_cnt - e0, 1);
        chk("drop sclk count", last_bits, 72);
        chk("drop sdio stream", last_mosi, {8'h00, 8'h0E, 64'h0102030405060708});
        chk("n8 write latency", t_upd - tl, LAT8);
        chk("release reply count", n_rep - r0, 1);
        chk("release reply", rep[r0], 8'hA5);

        chk("tx_start spacing", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
